// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined saturating ALU with valid/ready handshakes
// Optional N/Z/V flag register is present only when ALU_FLAGS_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam int NB = WIDTH / 8;
  localparam int NN = WIDTH / 4;

  logic                 s1_valid;
  logic                 s2_load;
  logic                 s1_load;

  logic                 is_sub;
  logic [WIDTH-1:0]     opb;
  logic [WIDTH-1:0]     sum_c;
  logic [WIDTH-1:0]     shf_c;
  logic [SHW-1:0]       amt;
  logic [SHW:0]         rot_amt;
  logic [NN-1:0][4:0]   pl_c;
  logic [NB-1:0][8:0]   rl_c;

  logic [3:0]           s1_op;
  logic [WIDTH-1:0]     s1_sum;
  logic                 s1_as;
  logic                 s1_bs;
  logic [WIDTH-1:0]     s1_shf;
  logic [WIDTH-1:0]     s1_xor;
  logic [NN-1:0][4:0]   s1_pl;
  logic [NB-1:0][8:0]   s1_rl;

  logic                 ovf;
  logic [WIDTH-1:0]     add_res;
  logic [WIDTH-1:0]     pad_res;
  logic [WIDTH-1:0]     red_sum;
  logic [WIDTH-1:0]     res;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // SUB feeds ~in2 with carry-in so the sign rule on (in1, ~in2) detects overflow exactly.
  always_comb begin
    is_sub  = (opcode == 4'b0001);
    opb     = is_sub ? ~in2 : in2;
    sum_c   = in1 + opb + {{(WIDTH-1){1'b0}}, is_sub};
    amt     = in2[SHW-1:0];
    rot_amt = (SHW+1)'(WIDTH) - {1'b0, amt};
    case (opcode[1:0])
      2'b00:   shf_c = in1 << amt;
      2'b01:   shf_c = $signed(in1) >>> amt;
      default: shf_c = (in1 >> amt) | (in1 << rot_amt);
    endcase
    pl_c = '0;
    for (int i = 0; i < NN; i++) begin
      pl_c[i] = {in1[4*i+3], in1[4*i +: 4]} + {in2[4*i+3], in2[4*i +: 4]};
    end
    rl_c = '0;
    for (int i = 0; i < NB; i++) begin
      rl_c[i] = {in1[8*i+7], in1[8*i +: 8]} + {in2[8*i+7], in2[8*i +: 8]};
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && s1_load) begin
      s1_op  <= opcode;
      s1_sum <= sum_c;
      s1_as  <= in1[WIDTH-1];
      s1_bs  <= opb[WIDTH-1];
      s1_shf <= shf_c;
      s1_xor <= in1 ^ in2;
      s1_pl  <= pl_c;
      s1_rl  <= rl_c;
    end
  end

  always_comb begin
    ovf = (s1_as == s1_bs) && (s1_sum[WIDTH-1] != s1_as);
    if (ovf) begin
      add_res = s1_as ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      add_res = s1_sum;
    end
    pad_res = '0;
    for (int i = 0; i < NN; i++) begin
      if (s1_pl[i][4] != s1_pl[i][3]) begin
        pad_res[4*i +: 4] = s1_pl[i][4] ? 4'h8 : 4'h7;
      end else begin
        pad_res[4*i +: 4] = s1_pl[i][3:0];
      end
    end
    red_sum = '0;
    for (int i = 0; i < NB; i++) begin
      red_sum = red_sum + {{(WIDTH-9){s1_rl[i][8]}}, s1_rl[i]};
    end
    casez (s1_op)
      4'b000?, 4'b10??: res = add_res;
      4'b0010, 4'b11??: res = s1_xor;
      4'b0011:          res = red_sum;
      4'b0111:          res = pad_res;
      default:          res = s1_shf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) out_valid <= s1_valid;
      if (s2_load && s1_valid) out <= res;
    end
  end

`ifdef ALU_FLAGS_EN
  logic p_wnv, p_wz, p_n, p_z, p_v;
  logic f_n, f_z, f_v;

  // Pending flags travel with the result and commit only when it is consumed.
  always_ff @(posedge clk) begin
    if (s2_load && s1_valid) begin
      p_wnv <= (s1_op[3:1] == 3'b000);
      p_wz  <= (s1_op[3:1] == 3'b000) || (s1_op == 4'b0010) || (s1_op == 4'b0100) ||
               (s1_op == 4'b0101) || (s1_op == 4'b0110);
      p_n   <= res[WIDTH-1];
      p_z   <= (res == '0);
      p_v   <= ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_n <= 1'b0;
      f_z <= 1'b0;
      f_v <= 1'b0;
    end else if (out_valid && out_ready) begin
      if (p_wnv) begin
        f_n <= p_n;
        f_v <= p_v;
      end
      if (p_wz) f_z <= p_z;
    end
  end

  assign flag_n = f_n;
  assign flag_z = f_z;
  assign flag_v = f_v;
`else
  assign flag_n = 1'b0;
  assign flag_z = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule
